// File: rtl/fft_mag_readout.sv
// Streams the FFT result RAM after each transform, converts each bin to an approximate
// magnitude (max + 3/8 min), and packs even/odd bin pairs into 32-bit words for the packer.
module fft_mag_readout #(
  parameter int NBINS = 256,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_done,
  input  logic          spi_busy,
  input  logic [31:0]   rd_data,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_start,
  output logic [31:0]   out_word,
  output logic          out_valid,
  output logic          busy,
  output logic          readout_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_nxt;

  logic        frame_done_q;
  logic        pending;
  logic        accept;
  logic        last_addr;
  logic        pipe_empty;

  logic        dat_vld, dat_odd;
  logic        s1_vld, s1_odd;
  logic [15:0] abs_re, abs_im;
  logic        s2_vld, s2_odd;
  logic [15:0] mag;
  logic [15:0] even_mag;

  logic [15:0] mag_max, mag_min, mag_sum;

  // -32768 has no positive counterpart, so it saturates to 32767
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    if (x == 16'h8000)
      return 16'h7fff;
    else if (x[15])
      return ~x + 16'd1;
    else
      return x;
  endfunction

  assign rd_en      = (state == READ);
  assign busy       = (state != IDLE);
  assign last_addr  = (rd_addr == AW'(NBINS - 1));
  assign pipe_empty = !dat_vld && !s1_vld && !s2_vld;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pending && !spi_busy) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (last_addr)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (readout_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Worst case 32767 + 8191 + 4095 = 45053 fits in 16 bits
  always_comb begin
    mag_max = (abs_re > abs_im) ? abs_re : abs_im;
    mag_min = (abs_re > abs_im) ? abs_im : abs_re;
    mag_sum = mag_max + {2'b00, mag_min[15:2]} + {3'b000, mag_min[15:3]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      frame_done_q <= 1'b0;
      pending      <= 1'b0;
      out_start    <= 1'b0;
      rd_addr      <= '0;
      readout_done <= 1'b0;
      dat_vld      <= 1'b0;
      dat_odd      <= 1'b0;
      s1_vld       <= 1'b0;
      s1_odd       <= 1'b0;
      abs_re       <= '0;
      abs_im       <= '0;
      s2_vld       <= 1'b0;
      s2_odd       <= 1'b0;
      mag          <= '0;
      even_mag     <= '0;
      out_word     <= '0;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= frame_done;
      // An edge arriving in the accept cycle re-arms pending for the next readout
      pending      <= (frame_done && !frame_done_q) || (pending && !accept);
      out_start    <= accept;

      if (state == READ)
        rd_addr <= last_addr ? '0 : rd_addr + AW'(1);

      // Final word has left and nothing is still in flight
      readout_done <= (state == DRAIN) && out_valid && pipe_empty;

      dat_vld <= rd_en;
      dat_odd <= rd_addr[0];

      s1_vld <= dat_vld;
      s1_odd <= dat_odd;
      if (dat_vld) begin
        abs_re <= sat_abs(rd_data[31:16]);
        abs_im <= sat_abs(rd_data[15:0]);
      end

      s2_vld <= s1_vld;
      s2_odd <= s1_odd;
      if (s1_vld)
        mag <= mag_sum;

      out_valid <= s2_vld && s2_odd;
      if (s2_vld && !s2_odd)
        even_mag <= mag;
      if (s2_vld && s2_odd)
        out_word <= {even_mag, mag};
    end
  end

endmodule

// File: tb/tb_fft_mag_readout.sv
// Directed/randomized bench for fft_mag_readout: RAM model, magnitude reference model,
// cycle-accurate frame timing checks, SPI deferral, overlap, level-hold and reset cases.
module tb_fft_mag_readout;

  localparam int NB = 256;
  localparam int AW = 9;
  localparam int NW = NB / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_done = 1'b0;
  logic          spi_busy = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_start;
  logic [31:0]   out_word;
  logic          out_valid;
  logic          busy;
  logic          readout_done;

  logic [31:0] mem   [NB];
  logic [31:0] exp_w [NW];

  int n_pass  = 0;
  int n_total = 0;

  fft_mag_readout #(.NBINS(NB), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_done   (frame_done),
    .spi_busy     (spi_busy),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .out_start    (out_start),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .busy         (busy),
    .readout_done (readout_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data one cycle after address/enable
  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= mem[rd_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mag(input logic [31:0] w);
    int re, im, a, b, mx, mn;
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 16'(mx + mn / 4 + mn / 8);
  endfunction

  task automatic build_exp();
    for (int k = 0; k < NW; k++)
      exp_w[k] = {ref_mag(mem[2*k]), ref_mag(mem[2*k+1])};
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (out_start !== 1'b1 && waited < maxc);
  endtask

  // Called at the negedge of cycle 1 (out_start seen); runs through cycle NB+6 (back in IDLE)
  task automatic run_frame(input string tag, input int retrig, output int nw, output logic [31:0] first_w);
    int  e_addr, e_time, e_word;
    logic exp_rd, exp_v;
    e_addr = 0; e_time = 0; e_word = 0; nw = 0; first_w = 'x;
    if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) e_addr++;
    for (int c = 2; c <= NB + 6; c++) begin
      @(negedge clk);
      if (retrig != 0 && c == retrig) frame_done = 1'b1;
      else if (retrig != 0 && c == retrig + 1) frame_done = 1'b0;
      exp_rd = (c <= NB);
      if (rd_en !== exp_rd || (exp_rd && rd_addr !== AW'(c - 1))) e_addr++;
      exp_v = (c >= 6 && c <= NB + 4 && (c % 2) == 0);
      if (out_valid !== exp_v || busy !== (c <= NB + 5) ||
          readout_done !== (c == NB + 5) || out_start !== 1'b0) e_time++;
      if (out_valid === 1'b1) begin
        if (nw == 0) first_w = out_word;
        if (nw < NW && out_word !== exp_w[nw]) e_word++;
        nw++;
      end
    end
    chk({tag, "_rd_seq_errs"}, e_addr, 0);
    chk({tag, "_timing_errs"}, e_time, 0);
    chk({tag, "_word_errs"}, e_word, 0);
    chk({tag, "_word_count"}, nw, NW);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_out_start"}, out_start, 0);
    chk({tag, "_out_word"}, out_word, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_readout_done"}, readout_done, 0);
  endtask

  initial begin
    int w, nw, nw2, errs, starts, valids;
    logic [31:0] fw;

    for (int i = 0; i < NB; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Constant frame: {-800, 400} -> 950 per bin
    for (int i = 0; i < NB; i++) mem[i] = {16'hFCE0, 16'h0190};
    build_exp();
    pulse_frame();
    wait_start(20, w);
    chk("const_start_lat", w, 1);
    run_frame("const", 0, nw, fw);
    chk("const_word0", fw, 32'h03B603B6);

    // Ordering and saturation
    for (int i = 0; i < NB; i++) mem[i] = '0;
    mem[0] = 32'h8000_8000;
    mem[1] = {16'd3, 16'd4};
    build_exp();
    pulse_frame();
    wait_start(20, w);
    chk("sat_start_lat", w, 1);
    run_frame("sat", 0, nw, fw);
    chk("sat_word0", fw, 32'hAFFD0004);

    // Randomized frames with a few forced extreme bins
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NB; i++) mem[i] = $urandom;
      mem[$urandom_range(0, NB-1)] = 32'h8000_8000;
      mem[$urandom_range(0, NB-1)] = 32'h7FFF_8000;
      mem[$urandom_range(0, NB-1)] = 32'h8000_0001;
      build_exp();
      pulse_frame();
      wait_start(20, w);
      chk("rand_start_lat", w, 1);
      run_frame("rand", 0, nw, fw);
    end

    // SPI deferral, then a new edge landing on the accept cycle
    spi_busy = 1'b1;
    pulse_frame();
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || busy !== 1'b0 || out_start !== 1'b0) errs++;
    end
    chk("spi_hold_errs", errs, 0);
    spi_busy   = 1'b0;
    frame_done = 1'b1;
    wait_start(20, w);
    chk("spi_start_lat", w, 1);
    frame_done = 1'b0;
    run_frame("spi", 0, nw, fw);
    wait_start(20, w);
    chk("accept_edge_lat", w, 1);
    run_frame("accept_edge", 0, nw, fw);

    // Overlap: second request at cycle 100 of the first readout
    for (int i = 0; i < NB; i++) mem[i] = $urandom;
    build_exp();
    pulse_frame();
    wait_start(20, w);
    chk("ovl_start_lat", w, 1);
    run_frame("ovl_a", 100, nw, fw);
    wait_start(20, w);
    chk("ovl_second_lat", w, 1);
    run_frame("ovl_b", 0, nw2, fw);
    chk("ovl_total_words", nw + nw2, 2 * NW);

    // Level hold: only the rising edge counts
    starts = 0; valids = 0;
    frame_done = 1'b1;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (i == 999) frame_done = 1'b0;
      if (out_start === 1'b1) starts++;
      if (out_valid === 1'b1) valids++;
    end
    chk("hold_starts", starts, 1);
    chk("hold_words", valids, NW);

    // Asynchronous reset mid-READ at address 100
    pulse_frame();
    wait_start(20, w);
    chk("mid_start_lat", w, 1);
    w = 0;
    while (rd_addr !== AW'(100) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("mid_reached_100", rd_addr, 100);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    valids = 0; starts = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) valids++;
      if (busy === 1'b1) starts++;
    end
    chk("post_rst_words", valids, 0);
    chk("post_rst_busy", starts, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
